qr_frame_tx: RTL and testbench
==============================

// Module: qr_frame_tx
// PURPOSE
//  Transmit side of the QR_Engine input interface. Buffers complex samples written by the host/DMA side.
//  Streams each complete frame (4x4 channel H plus 4-entry y) to QR_Engine as an unbroken burst on o_trig/o_data.
//  Inserts a programmable idle gap between frames so the engine can finish each decomposition.
//  Sits between the system data source and the QR_Engine i_trig/i_data ports.
// PARAMETERS
//  DATA_W      16  width of one real or imaginary part (two's complement)
//  FRAME_LEN   20  words per frame: 16 H entries then 4 y entries
//  DEPTH       64  buffer depth in words; power of two, >= FRAME_LEN
//  GAP_CYCLES  8   idle cycles forced between bursts; must be >= 1
// PORTS
//  i_clk        in   1          clock, rising edge
//  i_rst_n      in   1          asynchronous active-low reset
//  i_clr        in   1          synchronous flush/abort, active high
//  s_valid      in   1          host word valid
//  s_data       in   2*DATA_W   host word {re, im}
//  s_ready      out  1          buffer can accept a word this cycle
//  o_trig       out  1          to QR_Engine i_trig: o_data valid this cycle
//  o_data       out  2*DATA_W   to QR_Engine i_data: {re, im}
//  o_busy       out  1          high in SEND or GAP
//  o_frame_cnt  out  16         number of frames fully emitted, wraps
// BEHAVIOUR
//  - Reset: buffer empty, state IDLE, o_trig=0, o_data=0, o_busy=0, o_frame_cnt=0.
//    s_ready is forced 0 while i_rst_n is low.
//  - Push: a word is accepted when s_valid && s_ready. s_ready = (count<DEPTH) && !i_clr.
//    s_valid without s_ready is not accepted; the host holds the word.
//  - Pop and push in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
//  - Word order within a frame: H column-major (H[0][0], H[1][0] .. H[3][3]), then y[0]..y[3].
//    Order is preserved bit-exact.
//  - FSM:
//    IDLE: if count>=FRAME_LEN, pop the first word and go to SEND with idx=0.
//          A partial frame is never started.
//    SEND: pop one word per cycle, FRAME_LEN words total. On the last pop go to GAP.
//    GAP:  count GAP_CYCLES cycles, then go to IDLE. The IDLE check runs on the following cycle.
//  - Outputs o_trig and o_data are registered. A word popped in cycle t appears in cycle t+1.
//  - Latency: 20th word accepted at edge t. IDLE sees count=20 in cycle t+1.
//    o_trig is high in cycles t+2..t+21, with no holes.
//  - Back-to-back frames: o_trig low for exactly GAP_CYCLES+1 cycles between bursts.
//  - o_data holds its last value while o_trig=0. Only o_trig qualifies o_data.
//  - o_frame_cnt increments in the cycle the last word of a frame is driven. It wraps 0xFFFF->0.
//  - i_clr: takes effect next edge. It empties the buffer, returns to IDLE, and clears o_trig,
//    o_busy and o_frame_cnt. An aborted partial burst is not counted.
//    i_clr overrides a same-cycle push.
//  - Async reset mid-burst: all outputs return to reset values immediately. No residual words are sent.
//  - No arithmetic on sample data; only pointer/count/idx/gap counters.
//    count width = log2(DEPTH)+1.
// STRUCTURE
//  - qr_pkg holds: DATA_W, FRAME_LEN, H_DIM=4, typedef cplx_t {logic signed [DATA_W-1:0] re, im},
//    and the state enum {IDLE, SEND, GAP}.
//    QR_Engine and the bench share this package.
//  - One sub-module, qr_sync_fifo: push/pop, count, full/empty, flush.
//    It is a single-clock RAM or flop array with read data available one cycle after pop.
//  - The top level holds the FSM, idx counter, gap counter, frame counter and output registers.
// TESTING
//  1. Reset: hold i_rst_n=0 for 2 cycles, then release.
//     Require o_trig=0, o_data=0, o_frame_cnt=0, o_busy=0, s_ready=1.
//  2. Single frame: write 20 words back to back. Word0={-5066,10028}, word k={k,-k} for k>=1.
//     Require o_trig high for exactly 20 cycles from 2 cycles after the last accept.
//     First o_data=32'hEC36_272C, all words in order, o_frame_cnt=1.
//  3. Partial frame: write 19 words and wait 100 cycles; o_trig must stay 0.
//     Write the 20th word; the burst starts 2 cycles later.
//  4. Back-to-back: GAP_CYCLES=4, write 40 words continuously.
//     Require two 20-cycle bursts separated by exactly 5 low cycles, and o_frame_cnt=2.
//  5. Backpressure: keep s_valid high for 70 words.
//     s_ready drops when count reaches 64. The scoreboard must see no lost or duplicated words.
//     Count stays constant on simultaneous push and pop.
//  6. Abort: pulse i_clr during burst word 7.
//     Require o_trig=0 next cycle, s_ready=1, o_frame_cnt=0.
//     A fresh 20-word frame then transmits cleanly. Repeat the run with i_rst_n pulsed instead of i_clr.

Source files
------------

// File: rtl/qr_pkg.sv
// Shared types for the QR_Engine input path: sample format, frame geometry and
// the frame transmitter state encoding.
package qr_pkg;

   localparam int DATA_W    = 16;
   localparam int FRAME_LEN = 20;
   localparam int H_DIM     = 4;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

endpackage

// File: rtl/qr_sync_fifo.sv
// Single-clock word buffer with occupancy count and flush. Read data is
// registered: a word popped in one cycle is presented on rdata the next.
module qr_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    push,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    pop,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Output word holds between pops; flush leaves it untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      rdata <= '0;
      else if (do_pop) rdata <= mem[rd_ptr];
   end

endmodule

// File: rtl/qr_frame_tx.sv
// Frame transmitter: buffers host words and streams complete 20-word frames
// (H column-major, then y) to QR_Engine as unbroken bursts with an idle gap.
module qr_frame_tx #(
   parameter int DATA_W     = qr_pkg::DATA_W,
   parameter int FRAME_LEN  = qr_pkg::FRAME_LEN,
   parameter int DEPTH      = 64,
   parameter int GAP_CYCLES = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clr,
   input  logic                s_valid,
   input  logic [2*DATA_W-1:0] s_data,
   output logic                s_ready,
   output logic                o_trig,
   output logic [2*DATA_W-1:0] o_data,
   output logic                o_busy,
   output logic [15:0]         o_frame_cnt
);

   import qr_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
   localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 2);
   localparam logic [GW-1:0] GAP_END   = GW'(GAP_CYCLES);

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_nxt;
   logic [GW-1:0]   gap_cnt;
   logic [GW-1:0]   gap_nxt;
   logic            pop;
   logic            frame_done;
   logic            push;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;

   assign s_ready = i_rst_n && !full && !i_clr;
   assign push    = s_valid && s_ready;
   assign o_busy  = (state != IDLE);

   qr_sync_fifo #(
      .WIDTH (2*DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .flush (i_clr),
      .push  (push),
      .wdata (s_data),
      .pop   (pop),
      .rdata (o_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // idx is the index of the word popped in the previous cycle; word 0 leaves
   // from IDLE, so SEND ends after popping word FRAME_LEN-1 (idx == FRAME_LEN-2).
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      gap_nxt    = gap_cnt;
      pop        = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (count >= FRAME_CNT) begin
               pop       = 1'b1;
               idx_nxt   = '0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (!empty) begin
               pop     = 1'b1;
               idx_nxt = idx + 1'b1;
               if (idx == LAST_IDX) begin
                  frame_done = 1'b1;
                  gap_nxt    = '0;
                  state_nxt  = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == GAP_END) state_nxt = IDLE;
            else                    gap_nxt   = gap_cnt + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // o_trig follows the pop by one cycle, aligned with the registered FIFO word.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         gap_cnt     <= '0;
         o_trig      <= 1'b0;
         o_frame_cnt <= '0;
      end else if (i_clr) begin
         state       <= IDLE;
         idx         <= '0;
         gap_cnt     <= '0;
         o_trig      <= 1'b0;
         o_frame_cnt <= '0;
      end else begin
         state   <= state_nxt;
         idx     <= idx_nxt;
         gap_cnt <= gap_nxt;
         o_trig  <= pop;
         if (frame_done) o_frame_cnt <= o_frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_qr_frame_tx.sv
// Directed bench for qr_frame_tx: reset, single/partial/back-to-back frames,
// buffer backpressure, and abort by i_clr and by asynchronous reset.
`timescale 1ns/1ps
module tb_qr_frame_tx;
   import qr_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, clr, valid;
   logic [31:0] data;
   logic        ready, trig, busy;
   logic [31:0] odata;
   logic [15:0] fcnt;
   logic        bp_clr, bp_valid;
   logic [31:0] bp_data;
   logic        bp_ready, bp_trig, bp_busy;
   logic [31:0] bp_odata;
   logic [15:0] bp_fcnt;

   int          cyc = 0;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [31:0] rx_q[$];
   int          rx_t[$];
   logic [31:0] bq[$];
   int          pp_seen = 0;
   int          pp_bad = 0;
   logic        pp_prev = 1'b0;
   logic [6:0]  pp_cnt = '0;
   int          stall_at, stall_cnt, last_acc, n_acc, e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   qr_frame_tx #(.DATA_W(16), .FRAME_LEN(20), .DEPTH(64), .GAP_CYCLES(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .s_valid(valid), .s_data(data),
      .s_ready(ready), .o_trig(trig), .o_data(odata), .o_busy(busy), .o_frame_cnt(fcnt));

   qr_frame_tx #(.DATA_W(16), .FRAME_LEN(20), .DEPTH(64), .GAP_CYCLES(100)) dut_bp (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(bp_clr), .s_valid(bp_valid), .s_data(bp_data),
      .s_ready(bp_ready), .o_trig(bp_trig), .o_data(bp_odata), .o_busy(bp_busy), .o_frame_cnt(bp_fcnt));

   // Output capture and push+pop occupancy tracking on the backpressure instance.
   always @(negedge clk) begin
      if (trig) begin
         rx_q.push_back(odata);
         rx_t.push_back(cyc);
      end
      if (bp_trig) bq.push_back(bp_odata);
      if (pp_prev && rst_n) begin
         pp_seen <= pp_seen + 1;
         if (dut_bp.u_fifo.count != pp_cnt) pp_bad <= pp_bad + 1;
      end
      pp_prev <= bp_valid && bp_ready && dut_bp.pop;
      pp_cnt  <= dut_bp.u_fifo.count;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish before 200us");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) tick();
   endtask

   function automatic logic [31:0] pat(input int base, input int k);
      cplx_t c;
      if (base == 0) begin
         if (k == 0) begin
            c.re = -16'sd5066;
            c.im = 16'sd10028;
         end else begin
            c.re = 16'(k);
            c.im = 16'(-k);
         end
      end else begin
         c = cplx_t'(32'(base + k));
      end
      return c;
   endfunction

   task automatic push(input bit to_bp, input logic [31:0] w);
      int   guard;
      logic ok;
      guard = 0;
      if (to_bp) begin
         bp_valid = 1'b1;
         bp_data  = w;
      end else begin
         valid = 1'b1;
         data  = w;
      end
      forever begin
         @(negedge clk);
         ok = to_bp ? bp_ready : ready;
         if (to_bp && !ok && stall_at < 0) begin
            stall_at  = n_acc;
            stall_cnt = int'(dut_bp.u_fifo.count);
         end
         tick();
         if (ok) break;
         guard++;
         if (guard > 400) begin
            n_chk++;
            $error("FAIL push_timeout: observed no accept expected accept within 400 cycles");
            break;
         end
      end
      n_acc++;
      last_acc = cyc;
   endtask

   task automatic chk_seq(input string tag, input int base, input int n, input bit from_bp);
      int          bad;
      logic [31:0] v;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         v = 'x;
         if (from_bp) begin
            if (i < bq.size()) v = bq[i];
         end else if (i < rx_q.size()) begin
            v = rx_q[i];
         end
         if (v !== pat(base, i)) bad++;
      end
      chk(tag, 32'(bad), 32'd0);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; valid = 1'b0; data = '0;
      bp_clr = 1'b0; bp_valid = 1'b0; bp_data = '0;
      stall_at = -1; stall_cnt = 0; n_acc = 0; last_acc = 0; e = 0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_low", 32'(ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_trig", 32'(trig), 32'd0);
      chk("rst_data", odata, 32'd0);
      chk("rst_fcnt", 32'(fcnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ready), 32'd1);
      tick();

      // Single frame
      clear_rx();
      for (int k = 0; k < 20; k++) push(1'b0, pat(0, k));
      valid = 1'b0;
      e = last_acc;
      wait_cyc(30);
      chk("t2_len", 32'(rx_q.size()), 32'd20);
      chk("t2_start", 32'(rx_t[0]), 32'(e + 1));
      chk("t2_contig", 32'(rx_t[19] - rx_t[0]), 32'd19);
      chk("t2_word0", rx_q[0], 32'hEC36_272C);
      chk_seq("t2_order", 0, 20, 1'b0);
      chk("t2_fcnt", 32'(fcnt), 32'd1);

      // Partial frame
      clear_rx();
      for (int k = 0; k < 19; k++) push(1'b0, pat(32'h3000, k));
      valid = 1'b0;
      wait_cyc(100);
      chk("t3_quiet", 32'(rx_q.size()), 32'd0);
      chk("t3_busy", 32'(busy), 32'd0);
      push(1'b0, pat(32'h3000, 19));
      valid = 1'b0;
      e = last_acc;
      wait_cyc(30);
      chk("t3_start", 32'(rx_t[0]), 32'(e + 1));
      chk("t3_len", 32'(rx_q.size()), 32'd20);
      chk_seq("t3_order", 32'h3000, 20, 1'b0);
      chk("t3_fcnt", 32'(fcnt), 32'd2);

      // Back-to-back frames
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("t4_clr_fcnt", 32'(fcnt), 32'd0);
      clear_rx();
      for (int k = 0; k < 40; k++) push(1'b0, pat(32'h4000, k));
      valid = 1'b0;
      wait_cyc(70);
      chk("t4_len", 32'(rx_q.size()), 32'd40);
      chk("t4_burst1", 32'(rx_t[19] - rx_t[0]), 32'd19);
      chk("t4_burst2", 32'(rx_t[39] - rx_t[20]), 32'd19);
      chk("t4_gap", 32'(rx_t[20] - rx_t[19]), 32'd6);
      chk_seq("t4_order", 32'h4000, 40, 1'b0);
      chk("t4_fcnt", 32'(fcnt), 32'd2);

      // Backpressure: fill the long-gap instance while it idles between frames
      bq.delete();
      for (int k = 0; k < 20; k++) push(1'b1, pat(32'h5000, k));
      bp_valid = 1'b0;
      wait_cyc(25);
      chk("bp_busy_gap", 32'(bp_busy), 32'd1);
      n_acc = 0;
      stall_at = -1;
      for (int k = 20; k < 90; k++) push(1'b1, pat(32'h5000, k));
      bp_valid = 1'b0;
      chk("bp_stall_at", 32'(stall_at), 32'd64);
      chk("bp_stall_count", 32'(stall_cnt), 32'd64);
      wait_cyc(400);
      chk("bp_len", 32'(bq.size()), 32'd80);
      chk_seq("bp_order", 32'h5000, 80, 1'b1);
      chk("bp_fcnt", 32'(bp_fcnt), 32'd4);
      chk("bp_pushpop_seen", 32'(pp_seen > 0), 32'd1);
      chk("bp_pushpop_count", 32'(pp_bad), 32'd0);
      bp_clr = 1'b1;
      tick();
      bp_clr = 1'b0;
      chk("bp_clr_fcnt", 32'(bp_fcnt), 32'd0);

      // Abort with i_clr during burst word 7
      clear_rx();
      for (int k = 0; k < 20; k++) push(1'b0, pat(32'h6000, k));
      valid = 1'b0;
      e = last_acc;
      while (cyc < e + 8) tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      @(negedge clk);
      chk("ab_trig", 32'(trig), 32'd0);
      chk("ab_ready", 32'(ready), 32'd1);
      chk("ab_fcnt", 32'(fcnt), 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      wait_cyc(30);
      chk("ab_words", 32'(rx_q.size()), 32'd8);
      clear_rx();
      for (int k = 0; k < 20; k++) push(1'b0, pat(32'h7000, k));
      valid = 1'b0;
      wait_cyc(30);
      chk("ab_fresh_len", 32'(rx_q.size()), 32'd20);
      chk_seq("ab_fresh_order", 32'h7000, 20, 1'b0);
      chk("ab_fresh_fcnt", 32'(fcnt), 32'd1);

      // Abort with asynchronous reset during burst word 7
      clear_rx();
      for (int k = 0; k < 20; k++) push(1'b0, pat(32'h8000, k));
      valid = 1'b0;
      e = last_acc;
      while (cyc < e + 8) tick();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rr_trig", 32'(trig), 32'd0);
      chk("rr_data", odata, 32'd0);
      chk("rr_busy", 32'(busy), 32'd0);
      chk("rr_fcnt", 32'(fcnt), 32'd0);
      chk("rr_ready", 32'(ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_cyc(30);
      chk("rr_words", 32'(rx_q.size()), 32'd8);
      clear_rx();
      for (int k = 0; k < 20; k++) push(1'b0, pat(32'h9000, k));
      valid = 1'b0;
      wait_cyc(30);
      chk("rr_fresh_len", 32'(rx_q.size()), 32'd20);
      chk_seq("rr_fresh_order", 32'h9000, 20, 1'b0);
      chk("rr_fresh_fcnt", 32'(fcnt), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
